// File: rtl/stream_tx_packer_if.sv
// Sample-in / FIFO-write bundle for the transmit packer.
// master = packer side (consumes samples, drives FIFO din/wr_en), slave = environment side.
// Ports: sample_in/sample_valid/sample_ready (byte stream), dout_32/wr_en_32/full_32 (FIFO write port).
interface stream_tx_packer_if;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] dout_32;
    logic        wr_en_32;
    logic        full_32;

    modport master (
        input  sample_in,
        input  sample_valid,
        input  full_32,
        output sample_ready,
        output dout_32,
        output wr_en_32
    );

    modport slave (
        output sample_in,
        output sample_valid,
        output full_32,
        input  sample_ready,
        input  dout_32,
        input  wr_en_32
    );
endinterface

// File: rtl/stream_tx_packer.sv
// Packs 8-bit samples little-endian into 32-bit words and writes framed packets
// (header, WORDS_PER_FRAME payload words, optional checksum trailer) into a host FIFO.
// Latency: 4th byte accepted -> word pending next cycle -> wr_en_32 as soon as full_32 is low.
// Backpressure: full_32 stalls the pending word indefinitely; sample_ready is low while a word is pending.
// Ports: clk, rst (async, active-high); bus (master modport: sample stream in, FIFO write port out);
//        busy (frame in progress), frame_done (1-cycle pulse), frame_count (completed frames, wraps).
// Build option: define STREAM_TX_CHECKSUM_EN to append a sum-mod-2^32 trailer of the payload words.
module stream_tx_packer #(
    parameter int unsigned WORDS_PER_FRAME = 16,
    parameter logic [15:0] HDR_MAGIC       = 16'hA55A
) (
    input  logic                      clk,
    input  logic                      rst,
    stream_tx_packer_if.master        bus,
    output logic                      busy,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);

    localparam logic [15:0] WPF16     = 16'(WORDS_PER_FRAME);
    localparam logic [15:0] LAST_WORD = 16'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
`ifdef STREAM_TX_CHECKSUM_EN
        S_CHECKSUM,
`endif
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] dout_q;
    logic        pending;
    logic [1:0]  byte_cnt;
    logic [15:0] word_cnt;
    logic [15:0] frame_count_q;
`ifdef STREAM_TX_CHECKSUM_EN
    logic [31:0] acc;
`endif

    logic ready;
    logic wr;
    logic accept;

    // Write and accept can never coincide: one needs pending set, the other clear.
    assign wr     = pending & ~bus.full_32;
    assign ready  = (state == S_PAYLOAD) & ~pending;
    assign accept = bus.sample_valid & ready;

    assign bus.dout_32      = dout_q;
    assign bus.wr_en_32     = wr;
    assign bus.sample_ready = ready;
    assign busy             = (state != S_IDLE);
    assign frame_done       = (state == S_DONE);
    assign frame_count      = frame_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            dout_q        <= 32'd0;
            pending       <= 1'b0;
            byte_cnt      <= 2'd0;
            word_cnt      <= 16'd0;
            frame_count_q <= 16'd0;
`ifdef STREAM_TX_CHECKSUM_EN
            acc           <= 32'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    byte_cnt <= 2'd0;
                    word_cnt <= 16'd0;
`ifdef STREAM_TX_CHECKSUM_EN
                    acc      <= 32'd0;
`endif
                    // The triggering sample stays on the bus; it is consumed in PAYLOAD.
                    if (bus.sample_valid) begin
                        dout_q  <= {HDR_MAGIC, WPF16};
                        pending <= 1'b1;
                        state   <= S_HEADER;
                    end
                end

                S_HEADER: begin
                    if (wr) begin
                        pending <= 1'b0;
                        state   <= S_PAYLOAD;
                    end
                end

                S_PAYLOAD: begin
                    // dout_q doubles as the assembly register: lanes are filled while
                    // nothing is pending, so the FIFO-facing word never moves mid-write.
                    if (accept) begin
                        dout_q[{byte_cnt, 3'b000} +: 8] <= bus.sample_in;
                        byte_cnt                        <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            pending <= 1'b1;
`ifdef STREAM_TX_CHECKSUM_EN
                            acc     <= acc + {bus.sample_in, dout_q[23:0]};
`endif
                        end
                    end
                    if (wr) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= 16'd0;
`ifdef STREAM_TX_CHECKSUM_EN
                            // Trailer is loaded on the same edge the last payload word leaves.
                            dout_q   <= acc;
                            pending  <= 1'b1;
                            state    <= S_CHECKSUM;
`else
                            pending  <= 1'b0;
                            state    <= S_DONE;
`endif
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                            pending  <= 1'b0;
                        end
                    end
                end

`ifdef STREAM_TX_CHECKSUM_EN
                S_CHECKSUM: begin
                    if (wr) begin
                        pending <= 1'b0;
                        state   <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    frame_count_q <= frame_count_q + 16'd1;
                    state         <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_tx_packer.sv
module tb_stream_tx_packer;

    localparam int WPF = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    stream_tx_packer_if bus ();

    stream_tx_packer #(
        .WORDS_PER_FRAME (WPF),
        .HDR_MAGIC       (16'hA55A)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected FIFO write stream: filled by the stimulus, drained by the monitor.
    logic [31:0] exp_mem [0:511];
    int          exp_wr = 0;
    int          exp_rd = 0;
    int          frames = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          full_mode = 0;   // 0: low, 1: held high, 2: random

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] w);
        exp_mem[exp_wr % 512] = w;
        exp_wr++;
    endtask

    // Full flag changes just after the edge, before the monitor's sample point.
    always @(posedge clk) begin
        #2;
        if (full_mode == 2) bus.full_32 = ($urandom_range(0, 2) == 0);
        else                bus.full_32 = (full_mode == 1);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en_32) begin
                if (exp_rd == exp_wr) begin
                    check("unexpected_write", {31'd0, bus.wr_en_32}, 32'd0);
                end else begin
                    check("wr_word", bus.dout_32, exp_mem[exp_rd % 512]);
                    exp_rd++;
                end
                check("ready_while_pending", {31'd0, bus.sample_ready}, 32'd0);
            end
            if (bus.full_32)
                check("wr_while_full", {31'd0, bus.wr_en_32}, 32'd0);
            if (frame_done)
                done_cnt++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        bit taken;
        taken = 1'b0;
        bus.sample_in    = b;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 400 && !taken; i++) begin
            @(negedge clk);
            taken = bus.sample_ready;
            @(posedge clk);
            #1;
        end
        if (!taken) check("accept_timeout", {31'd0, bus.sample_ready}, 32'd1);
        bus.sample_valid = 1'b0;
    endtask

    // mode 0: bytes 01,02,...; 1: all FF; 2: random. gap 0: back-to-back; 1: toggle; 2: random.
    task automatic send_frame(input int mode, input int gap, input bit stall_hdr);
        logic [7:0]  b [0:4*WPF-1];
        logic [31:0] w;
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = 0; i < 4*WPF; i++)
            b[i] = (mode == 0) ? 8'(i + 1) : (mode == 1) ? 8'hFF : 8'($urandom);
        push_exp({16'hA55A, 16'(WPF)});
        for (int k = 0; k < WPF; k++) begin
            w   = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
            sum = sum + w;
            push_exp(w);
        end
`ifdef STREAM_TX_CHECKSUM_EN
        push_exp(sum);
`endif
        frames++;
        if (stall_hdr) begin
            full_mode        = 1;
            bus.sample_in    = b[0];
            bus.sample_valid = 1'b1;
            @(posedge clk);
            #1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("stall_wr_en", {31'd0, bus.wr_en_32}, 32'd0);
                check("stall_dout", bus.dout_32, {16'hA55A, 16'(WPF)});
                @(posedge clk);
                #1;
            end
            full_mode = 0;
            @(negedge clk);
            check("hdr_release", {31'd0, bus.wr_en_32}, 32'd1);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 4*WPF; i++) begin
            send_byte(b[i]);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && ((exp_wr != exp_rd) || busy); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", {31'd0, (exp_wr == exp_rd) && !busy}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},  bus.dout_32, 32'd0);
        check({tag, "_wr_en"}, {31'd0, bus.wr_en_32}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.sample_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, frame_done}, 32'd0);
        check({tag, "_count"}, {16'd0, frame_count}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_in    = 8'd0;
        bus.sample_valid = 1'b0;
        bus.full_32      = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Bytes 01..08 back-to-back, FIFO never full.
        send_frame(0, 0, 1'b0);
        drain();
        check("count_after_first", {16'd0, frame_count}, 32'(frames));
        check("done_pulses_first", 32'(done_cnt - done_base), 32'(frames));

        // Same bytes with sample_valid toggling every cycle.
        send_frame(0, 1, 1'b0);
        drain();
        check("count_after_toggle", {16'd0, frame_count}, 32'(frames));

        // Header held off by full for 10 cycles.
        send_frame(0, 0, 1'b1);
        drain();

        // All-FF payload: exercises checksum wrap when enabled.
        send_frame(1, 0, 1'b0);
        drain();

        // Random data, random gaps, random backpressure.
        full_mode = 2;
        for (int f = 0; f < 8; f++)
            send_frame(2, 2, 1'b0);
        full_mode = 0;
        drain();
        check("count_after_random", {16'd0, frame_count}, 32'(frames));
        check("done_pulses_random", 32'(done_cnt - done_base), 32'(frames));

        // Reset after three payload bytes: outputs clear asynchronously.
        push_exp({16'hA55A, 16'(WPF)});
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("partial_no_write_left", 32'(exp_wr - exp_rd), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        frames    = 0;
        done_base = done_cnt;
        @(posedge clk);
        #1;
        send_frame(2, 0, 1'b0);
        drain();
        check("count_after_rst", {16'd0, frame_count}, 32'(frames));
        check("done_pulses_rst", 32'(done_cnt - done_base), 32'(frames));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
